instruction_fetch_unit: RTL and testbench
=========================================

INSTRUCTION_FETCH_UNIT -- requirements
Module: instruction_fetch_unit

Interface
REQ-001 SHALL provide parameter RESET_PC, default 32'h0000_0000, the first fetch address after reset; bits [1:0] SHALL be 0.
REQ-002 SHALL provide parameter QUEUE_DEPTH, default 2, the number of instruction queue entries; the only supported value is 2.
REQ-003 SHALL use one clock and an asynchronous, active-low reset: `clk  in  1  clock, all state on rising edge`; `clr_n  in  1  asynchronous active-low clear`.
REQ-004 SHALL provide `imem_req  out  1  single-cycle fetch request strobe`.
REQ-005 SHALL provide `imem_addr  out  32  word-aligned fetch address, valid while imem_req=1`.
REQ-006 SHALL provide `imem_rvalid  in  1  response strobe, at least one cycle after its request`.
REQ-007 SHALL provide `imem_rdata  in  32  instruction word, valid while imem_rvalid=1`.
REQ-008 SHALL provide `instr_valid  out  1  queue head valid toward decode/register file`.
REQ-009 SHALL provide `instr  out  32  queue head instruction word`.
REQ-010 SHALL provide `instr_pc  out  32  address of the queue head instruction`.
REQ-011 SHALL provide `instr_ready  in  1  decode accepts the head (handshake = instr_valid & instr_ready)`.
REQ-012 SHALL provide `redirect_en  in  1  branch/jump redirect, one-cycle pulse`.
REQ-013 SHALL provide `redirect_pc  in  32  redirect target; bits [1:0] ignored and treated as 0`.

Function
REQ-014 SHALL hold the fetch PC register (fpc) and SHALL allow at most one imem request outstanding.
REQ-015 SHALL implement FSM states: S_ISSUE (no request outstanding), S_WAIT (one valid request outstanding), S_DRAIN (one stale request outstanding).
REQ-016 SHALL assert imem_req with imem_addr=fpc in S_ISSUE, or in S_WAIT during an imem_rvalid cycle, when queue occupancy after this cycle's push and pop is below 2 and redirect_en=0.
REQ-017 On an issued request, SHALL set fpc to fpc+4 (32-bit wrap, 32'hFFFF_FFFC to 32'h0) and SHALL enter or stay in S_WAIT.
REQ-018 In S_WAIT, on imem_rvalid, SHALL push {imem_rdata, address of that request} into the queue and, if no new request is issued, SHALL return to S_ISSUE.
REQ-019 SHALL present the queue head on instr/instr_pc with instr_valid=1 whenever the queue is non-empty; an rvalid-to-instr_valid latency of 1 cycle SHALL apply when the queue is empty.
REQ-020 SHALL pop the head on handshake; a push and a pop in the same cycle SHALL leave occupancy unchanged.
REQ-021 SHALL hold instr and instr_pc stable while instr_valid=1 and instr_ready=0.
REQ-022 On redirect_en, SHALL flush the queue, set fpc={redirect_pc[31:2],2'b00}, and issue no request that cycle.
REQ-023 SHALL go to S_DRAIN on redirect_en if a request is outstanding whose response does not arrive that cycle; otherwise it SHALL go to S_ISSUE.
REQ-024 SHALL discard a response arriving in the redirect cycle or in S_DRAIN, and SHALL leave S_DRAIN for S_ISSUE on that response.
REQ-025 A handshake coinciding with redirect_en SHALL count as accepted by decode; the remaining entries SHALL still be flushed.
REQ-026 A second redirect_en in S_DRAIN SHALL update fpc and remain in S_DRAIN.
REQ-027 imem_rvalid in S_ISSUE SHALL be ignored.

Reset
REQ-028 On clr_n=0, asynchronously: state=S_ISSUE, fpc=RESET_PC, queue empty, imem_req=0, instr_valid=0, instr=0, instr_pc=0.
REQ-029 The first imem_req SHALL occur in the first cycle after clr_n deasserts, with imem_addr=RESET_PC.
REQ-030 Reset mid-operation SHALL abandon any outstanding request; a later response SHALL be ignored per REQ-027.

Structure
REQ-031 SHALL place the state enum (S_ISSUE/S_WAIT/S_DRAIN), the PC increment constant 4, and the RESET_PC default in the shared processor package.
REQ-032 SHALL implement the queue as sub-module fetch_queue: 2-entry, 64-bit, with push/pop/flush and occupancy output.

Verification
REQ-033 Reset release with a 1-cycle memory and instr_ready=1 -> requests issued at 0x0, 0x4, 0x8 on consecutive cycles; instr_pc sequence 0x0, 0x4, 0x8 at one per cycle after the first.
REQ-034 instr_ready=0 for 6 cycles -> exactly 2 entries held, imem_req=0 thereafter, instr/instr_pc stable; on release, no loss or duplication.
REQ-035 Redirect to 0x0000_0103 while a request is outstanding with latency 3 -> S_DRAIN, stale word dropped, next imem_addr=0x0000_0100, first instr_pc after redirect=0x100.
REQ-036 fpc=0xFFFF_FFFC -> the following request has imem_addr=0x0000_0000.
REQ-037 Redirect coincident with a handshake and with imem_rvalid -> handshaked word consumed once, rvalid word discarded, queue empty next cycle.
REQ-038 clr_n pulsed low mid-S_WAIT -> outputs immediately at reset values; the late rvalid is ignored; fetch restarts at RESET_PC.

Source files
------------

// File: rtl/instruction_fetch_unit_pkg.sv
// Shared processor definitions for the instruction fetch path: fetch FSM
// states, PC step, reset vector default and the queue entry layout.
package instruction_fetch_unit_pkg;

  typedef enum logic [1:0] {
    S_ISSUE = 2'd0,
    S_WAIT  = 2'd1,
    S_DRAIN = 2'd2
  } fetch_state_e;

  localparam logic [31:0] PC_INCR             = 32'd4;
  localparam logic [31:0] RESET_PC_DEFAULT    = 32'h0000_0000;
  localparam int unsigned QUEUE_DEPTH_DEFAULT = 2;

  // One queued instruction: word and the address it was fetched from.
  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } fetch_entry_t;

  // Clears the byte offset so every fetch address is word aligned.
  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return addr & 32'hFFFF_FFFC;
  endfunction

endpackage

// File: rtl/instruction_fetch_unit_if.sv
// Bundles the instruction memory port, the decode-side queue head and the
// redirect input of the fetch unit. master = fetch unit, slave = environment.
interface instruction_fetch_unit_if;

  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;

  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_ready;

  logic        redirect_en;
  logic [31:0] redirect_pc;

  modport master (
    output imem_req, imem_addr, instr_valid, instr, instr_pc,
    input  imem_rvalid, imem_rdata, instr_ready, redirect_en, redirect_pc
  );

  modport slave (
    input  imem_req, imem_addr, instr_valid, instr, instr_pc,
    output imem_rvalid, imem_rdata, instr_ready, redirect_en, redirect_pc
  );

endinterface

// File: rtl/instruction_fetch_unit_fetch_queue.sv
// Two-entry instruction queue between the memory response and decode.
// Head is read straight from the storage registers; flush wins over push/pop.
module fetch_queue
  import instruction_fetch_unit_pkg::*;
(
  input  logic         clk,
  input  logic         clr_n,
  input  logic         push_i,
  input  logic         pop_i,
  input  logic         flush_i,
  input  fetch_entry_t wdata_i,
  output fetch_entry_t head_o,
  output logic         valid_o,
  output logic [1:0]   count_o
);

  fetch_entry_t entry_q [2];
  logic         rd_ptr_q;
  logic         wr_ptr_q;
  logic [1:0]   count_q;
  logic [1:0]   count_d;
  logic         push_ok;
  logic         pop_ok;

  // Qualify push/pop against occupancy and compute the next occupancy.
  always_comb begin
    pop_ok  = pop_i && (count_q != 2'd0);
    push_ok = push_i && ((count_q != 2'd2) || pop_ok);
    count_d = count_q;
    if (flush_i) begin
      count_d = 2'd0;
    end else if (push_ok && !pop_ok) begin
      count_d = count_q + 2'd1;
    end else if (!push_ok && pop_ok) begin
      count_d = count_q - 2'd1;
    end
  end

  // Storage, pointers and occupancy; entries clear on reset so the head reads 0.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      entry_q[0] <= '0;
      entry_q[1] <= '0;
      rd_ptr_q   <= 1'b0;
      wr_ptr_q   <= 1'b0;
      count_q    <= 2'd0;
    end else begin
      count_q <= count_d;
      if (flush_i) begin
        rd_ptr_q <= 1'b0;
        wr_ptr_q <= 1'b0;
      end else begin
        if (push_ok) begin
          entry_q[wr_ptr_q] <= wdata_i;
          wr_ptr_q          <= ~wr_ptr_q;
        end
        if (pop_ok) begin
          rd_ptr_q <= ~rd_ptr_q;
        end
      end
    end
  end

  assign head_o  = entry_q[rd_ptr_q];
  assign valid_o = (count_q != 2'd0);
  assign count_o = count_q;

endmodule

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch unit: keeps the fetch PC, issues at most one memory
// request at a time and queues returned words for decode.
//
// state   | meaning
// S_ISSUE | no request outstanding
// S_WAIT  | one request outstanding, its response will be queued
// S_DRAIN | one stale request outstanding, its response will be dropped
//
// imem_req is combinational: issue depends on this cycle's response,
// handshake and redirect. It is gated by clr_n so it reads 0 during reset.
module instruction_fetch_unit
  import instruction_fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC    = RESET_PC_DEFAULT,
  parameter int unsigned QUEUE_DEPTH = QUEUE_DEPTH_DEFAULT
) (
  input  logic                      clk,
  input  logic                      clr_n,
  instruction_fetch_unit_if.master  fetch_if
);

  localparam logic [2:0] Q_FULL = 3'(QUEUE_DEPTH);

  fetch_state_e state_q;
  logic [31:0]  fpc_q;
  logic [31:0]  req_pc_q;

  fetch_entry_t q_head;
  fetch_entry_t q_wdata;
  logic         q_valid;
  logic [1:0]   q_count;
  logic         push;
  logic         pop;
  logic         issue;
  logic [2:0]   occ_next;

  // Response acceptance, decode handshake and the issue decision.
  always_comb begin
    pop      = q_valid && fetch_if.instr_ready;
    push     = (state_q == S_WAIT) && fetch_if.imem_rvalid && !fetch_if.redirect_en;
    occ_next = {1'b0, q_count} + {2'b00, push} - {2'b00, pop};
    issue    = clr_n && !fetch_if.redirect_en && (occ_next < Q_FULL) &&
               ((state_q == S_ISSUE) ||
                ((state_q == S_WAIT) && fetch_if.imem_rvalid));
    q_wdata  = '{instr: fetch_if.imem_rdata, pc: req_pc_q};
  end

  // Fetch FSM with fetch PC and the address of the outstanding request.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state_q  <= S_ISSUE;
      fpc_q    <= RESET_PC;
      req_pc_q <= '0;
    end else if (fetch_if.redirect_en) begin
      fpc_q <= word_align(fetch_if.redirect_pc);
      if ((state_q != S_ISSUE) && !fetch_if.imem_rvalid) begin
        state_q <= S_DRAIN;
      end else begin
        state_q <= S_ISSUE;
      end
    end else if (issue) begin
      fpc_q    <= fpc_q + PC_INCR;
      req_pc_q <= fpc_q;
      state_q  <= S_WAIT;
    end else begin
      case (state_q)
        S_WAIT:  if (fetch_if.imem_rvalid) state_q <= S_ISSUE;
        S_DRAIN: if (fetch_if.imem_rvalid) state_q <= S_ISSUE;
        default: state_q <= S_ISSUE;
      endcase
    end
  end

  fetch_queue u_queue (
    .clk     (clk),
    .clr_n   (clr_n),
    .push_i  (push),
    .pop_i   (pop),
    .flush_i (fetch_if.redirect_en),
    .wdata_i (q_wdata),
    .head_o  (q_head),
    .valid_o (q_valid),
    .count_o (q_count)
  );

  assign fetch_if.imem_req    = issue;
  assign fetch_if.imem_addr   = fpc_q;
  assign fetch_if.instr_valid = q_valid;
  assign fetch_if.instr       = q_head.instr;
  assign fetch_if.instr_pc    = q_head.pc;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed bench for instruction_fetch_unit. A small memory responder answers
// each request after a programmable latency with addr ^ 32'h1234_0000, or the
// steps drive the response by hand when the responder is switched off.
module tb_instruction_fetch_unit;
  import instruction_fetch_unit_pkg::*;

  logic        clk = 1'b0;
  logic        clr_n = 1'b0;
  logic        ready = 1'b0;
  logic        redir = 1'b0;
  logic [31:0] redir_pc = '0;
  logic        man_rvalid = 1'b0;
  logic [31:0] man_rdata = '0;
  logic        auto_rvalid = 1'b0;
  logic [31:0] auto_rdata = '0;
  logic        mem_auto = 1'b0;
  int          lat = 1;
  logic        pend = 1'b0;
  int          cnt = 0;
  logic [31:0] paddr = '0;
  int          n_pass = 0;
  int          n_chk = 0;

  instruction_fetch_unit_if bus ();

  assign bus.instr_ready = ready;
  assign bus.redirect_en = redir;
  assign bus.redirect_pc = redir_pc;
  assign bus.imem_rvalid = mem_auto ? auto_rvalid : man_rvalid;
  assign bus.imem_rdata  = mem_auto ? auto_rdata  : man_rdata;

  instruction_fetch_unit #(.RESET_PC(32'h0000_0000), .QUEUE_DEPTH(2)) dut (
    .clk      (clk),
    .clr_n    (clr_n),
    .fetch_if (bus)
  );

  initial forever #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'h1234_0000;
  endfunction

  // Memory responder: records requests at the negedge, answers after lat cycles.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (!mem_auto) begin
        pend        = 1'b0;
        auto_rvalid = 1'b0;
      end else if (pend && cnt == 1) begin
        auto_rvalid = 1'b1;
        auto_rdata  = mem_word(paddr);
        pend        = 1'b0;
      end else begin
        auto_rvalid = 1'b0;
        if (pend) cnt = cnt - 1;
      end
      @(negedge clk);
      if (mem_auto && bus.imem_req) begin
        pend  = 1'b1;
        cnt   = lat;
        paddr = bus.imem_addr;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic nxt;
    @(posedge clk);
    #1;
  endtask

  task automatic smp;
    @(negedge clk);
  endtask

  // Hold reset for two edges, then release at posedge+1 (cycle 0 of a test).
  task automatic do_reset(input int l, input logic auto_m);
    clr_n    = 1'b0;
    mem_auto = 1'b0;
    redir    = 1'b0;
    man_rvalid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    lat      = l;
    mem_auto = auto_m;
    clr_n    = 1'b1;
  endtask

  initial begin
    // reset state
    smp;
    chk("rst_req",   {31'b0, bus.imem_req},    32'h0);
    chk("rst_valid", {31'b0, bus.instr_valid}, 32'h0);
    chk("rst_instr", bus.instr,                32'h0);
    chk("rst_pc",    bus.instr_pc,             32'h0);

    // streaming with a 1-cycle memory
    ready = 1'b1;
    do_reset(1, 1'b1);
    smp;
    chk("c0_req",  {31'b0, bus.imem_req}, 32'h1);
    chk("c0_addr", bus.imem_addr,         32'h0);
    nxt; smp;
    chk("c1_req",  {31'b0, bus.imem_req}, 32'h1);
    chk("c1_addr", bus.imem_addr,         32'h4);
    nxt; smp;
    chk("c2_addr",  bus.imem_addr,            32'h8);
    chk("c2_valid", {31'b0, bus.instr_valid}, 32'h1);
    chk("c2_pc",    bus.instr_pc,             32'h0);
    chk("c2_instr", bus.instr,                32'h1234_0000);
    nxt; smp;
    chk("c3_pc",    bus.instr_pc, 32'h4);
    chk("c3_instr", bus.instr,    32'h1234_0004);
    nxt; smp;
    chk("c4_pc", bus.instr_pc, 32'h8);

    // decode stall for 6 cycles
    nxt; ready = 1'b0; smp;
    chk("c5_req", {31'b0, bus.imem_req}, 32'h0);
    chk("c5_pc",  bus.instr_pc,          32'hC);
    for (int i = 0; i < 5; i++) begin
      nxt; smp;
      chk("stall_req", {31'b0, bus.imem_req}, 32'h0);
      chk("stall_pc",  bus.instr_pc,          32'hC);
    end
    chk("stall_instr", bus.instr,                32'h1234_000C);
    chk("stall_valid", {31'b0, bus.instr_valid}, 32'h1);
    nxt; ready = 1'b1; smp;
    chk("c11_req",  {31'b0, bus.imem_req}, 32'h1);
    chk("c11_addr", bus.imem_addr,         32'h14);
    chk("c11_pc",   bus.instr_pc,          32'hC);
    nxt; smp;
    chk("c12_pc",    bus.instr_pc, 32'h10);
    chk("c12_instr", bus.instr,    32'h1234_0010);
    nxt; smp;
    chk("c13_pc", bus.instr_pc, 32'h14);
    nxt; smp;
    chk("c14_pc", bus.instr_pc, 32'h18);

    // redirect with a 3-cycle memory, stale response dropped
    do_reset(3, 1'b1);
    smp;
    chk("d0_addr", bus.imem_addr, 32'h0);
    nxt; redir = 1'b1; redir_pc = 32'h0000_0103; smp;
    chk("d1_req", {31'b0, bus.imem_req}, 32'h0);
    nxt; redir = 1'b0; smp;
    chk("d2_req", {31'b0, bus.imem_req}, 32'h0);
    nxt; smp;
    chk("d3_req",   {31'b0, bus.imem_req},    32'h0);
    chk("d3_valid", {31'b0, bus.instr_valid}, 32'h0);
    nxt; smp;
    chk("d4_req",   {31'b0, bus.imem_req},    32'h1);
    chk("d4_addr",  bus.imem_addr,            32'h100);
    chk("d4_valid", {31'b0, bus.instr_valid}, 32'h0);
    nxt; smp;
    nxt; smp;
    nxt; smp;
    chk("d7_valid", {31'b0, bus.instr_valid}, 32'h0);
    nxt; smp;
    chk("d8_valid", {31'b0, bus.instr_valid}, 32'h1);
    chk("d8_pc",    bus.instr_pc,             32'h100);
    chk("d8_instr", bus.instr,                32'h1234_0100);

    // PC wrap, then redirect coinciding with handshake and rvalid
    do_reset(1, 1'b1);
    smp;
    nxt; redir = 1'b1; redir_pc = 32'hFFFF_FFFE; smp;
    chk("e1_req", {31'b0, bus.imem_req}, 32'h0);
    nxt; redir = 1'b0; smp;
    chk("e2_addr", bus.imem_addr, 32'hFFFF_FFFC);
    nxt; smp;
    chk("e3_req",  {31'b0, bus.imem_req}, 32'h1);
    chk("e3_addr", bus.imem_addr,         32'h0);
    nxt; redir = 1'b1; redir_pc = 32'h0000_0200; smp;
    chk("e4_pc",    bus.instr_pc,          32'hFFFF_FFFC);
    chk("e4_instr", bus.instr,             32'hEDCB_FFFC);
    chk("e4_req",   {31'b0, bus.imem_req}, 32'h0);
    nxt; redir = 1'b0; smp;
    chk("e5_valid", {31'b0, bus.instr_valid}, 32'h0);
    chk("e5_addr",  bus.imem_addr,            32'h200);
    nxt; smp;
    chk("e6_valid", {31'b0, bus.instr_valid}, 32'h0);
    nxt; smp;
    chk("e7_pc",    bus.instr_pc, 32'h200);
    chk("e7_instr", bus.instr,    32'h1234_0200);

    // reset pulse while waiting, late response ignored
    ready = 1'b0;
    do_reset(1, 1'b0);
    smp;
    chk("f0_req", {31'b0, bus.imem_req}, 32'h1);
    nxt; man_rvalid = 1'b1; man_rdata = 32'hCAFE_0000; smp;
    chk("f1_addr", bus.imem_addr, 32'h4);
    nxt; man_rvalid = 1'b0; smp;
    chk("f2_instr", bus.instr,             32'hCAFE_0000);
    chk("f2_req",   {31'b0, bus.imem_req}, 32'h0);
    #1 clr_n = 1'b0;
    #1;
    chk("arst_req",   {31'b0, bus.imem_req},    32'h0);
    chk("arst_valid", {31'b0, bus.instr_valid}, 32'h0);
    chk("arst_instr", bus.instr,                32'h0);
    nxt; clr_n = 1'b1; man_rvalid = 1'b1; man_rdata = 32'hBAD0_0004; smp;
    chk("f3_req",  {31'b0, bus.imem_req}, 32'h1);
    chk("f3_addr", bus.imem_addr,         32'h0);
    nxt; man_rvalid = 1'b1; man_rdata = 32'h600D_0000; smp;
    chk("f4_valid", {31'b0, bus.instr_valid}, 32'h0);
    nxt; man_rvalid = 1'b0; smp;
    chk("f5_valid", {31'b0, bus.instr_valid}, 32'h1);
    chk("f5_pc",    bus.instr_pc,             32'h0);
    chk("f5_instr", bus.instr,                32'h600D_0000);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
